// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and TX FSM states (parity state only with UART_PARITY_EN)
package uart_pkg;
  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DIV    = 4'h8;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read; a push on a full FIFO is accepted when a pop happens on the same edge
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr, w_rd;
  assign full  = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign count = r_cnt;
  assign dout  = r_mem[r_rp];
  assign w_wr  = push && (!full || pop);
  assign w_rd  = pop && !empty;
  // pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  // storage needs no reset; only slots below the write pointer are ever read
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter (TXDATA/STATUS/DIV) with TX FIFO; UART_PARITY_EN adds an even-parity bit
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         re,
  input  logic [3:0]   addr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         tx,
  output logic         irq
);
  state_t                 r_state, w_next;
  logic                   r_ovf;
  logic [15:0]            r_div, r_div_lat, r_cnt;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic [7:0]             w_dout;
  logic                   w_full, w_empty, w_pop, w_tick, w_wr_tx, w_busy;
  logic [$clog2(DEPTH):0] w_count;
  logic [3:0]             w_status;
  logic                   w_unused;
`ifdef UART_PARITY_EN
  logic                   r_par;
`endif
  assign w_unused = ^wdata;
  assign w_wr_tx  = we && addr == ADDR_TXDATA;
  assign w_busy   = r_state != S_IDLE;
  assign w_tick   = r_cnt == r_div_lat - 16'd1;
  assign irq      = w_count == '0 && r_state == S_IDLE;
  assign w_status[ST_BUSY]  = w_busy;
  assign w_status[ST_FULL]  = w_full;
  assign w_status[ST_EMPTY] = w_empty;
  assign w_status[ST_OVF]   = r_ovf;
  assign rdata = addr == ADDR_STATUS ? W'(w_status) : addr == ADDR_DIV ? W'(r_div) : '0;
`ifdef UART_PARITY_EN
  assign tx = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_shift[0] : r_state == S_PARITY ? r_par : 1'b1;
`else
  assign tx = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_shift[0] : 1'b1;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_wr_tx),
    .pop   (w_pop),
    .din   (wdata[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // register file: sticky overflow (set beats a clearing STATUS read) and divisor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_div <= 16'(CLK_DIV);
    end else begin
      r_ovf <= (w_wr_tx && w_full && !w_pop) || (r_ovf && !(re && addr == ADDR_STATUS));
      if (we && addr == ADDR_DIV) r_div <= wdata[15:0];
    end
  end

  // FSM state register; reset forces IDLE so tx returns high without waiting for a clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // next state and FIFO pop; STOP chains straight into START when more bytes are queued
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop  = 1'b1;
        w_next = S_START;
      end
      S_START: if (w_tick) w_next = S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (w_tick && r_bit == 3'd7) w_next = S_PARITY;
      S_PARITY: if (w_tick) w_next = S_STOP;
`else
      S_DATA:   if (w_tick && r_bit == 3'd7) w_next = S_STOP;
`endif
      S_STOP: if (w_tick) begin
        w_pop  = !w_empty;
        w_next = w_empty ? S_IDLE : S_START;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // frame datapath: byte and divisor are latched at the pop so DIV writes only affect later frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_div_lat <= eff_div(16'(CLK_DIV));
      r_cnt     <= '0;
      r_bit     <= '0;
`ifdef UART_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else if (w_pop) begin
      r_shift   <= w_dout;
      r_div_lat <= eff_div(r_div);
      r_cnt     <= '0;
      r_bit     <= '0;
`ifdef UART_PARITY_EN
      r_par     <= ^w_dout;
`endif
    end else if (w_busy) begin
      r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
      if (w_tick && r_state == S_DATA) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: directed scenario tasks checking register access and serial waveforms of uart_tx_periph
module tb_uart_tx_periph;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst, we, re, tx, irq;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic        hist [HN];
  int          cyc = 0;
  int          nc = 0;
  int          nf = 0;

  uart_tx_periph #(.W(32), .DEPTH(4), .CLK_DIV(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    hist[cyc % HN] = tx;
    cyc = cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exhausted, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic store(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    addr = a;
    re = 1'b1;
    #1 v = rdata;
    tick();
    re = 1'b0;
  endtask

  task automatic wait_until(input int n);
    for (int i = 0; i < 20000 && cyc < n; i++) tick();
  endtask

  function automatic int find_low(input int from, input int to);
    for (int i = from; i < to; i++) if (hist[i % HN] === 1'b0) return i;
    return -1;
  endfunction

  // count samples that differ from an ideal frame of byte b at divisor d starting at s
  function automatic int frame_err(input int s, input logic [7:0] b, input int d);
    int e = 0;
    logic x;
    for (int i = 0; i < NB; i++) begin
      x = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : (i == 9 && NB == 11) ? ^b : 1'b1;
      for (int k = 0; k < d; k++) if (hist[(s + i*d + k) % HN] !== x) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = 4'h0; wdata = '0;
    repeat (3) tick();
    nc++; if (tx !== 1'b1) begin nf++; $display("FAIL reset_tx: got %b want 1", tx); end
    nc++; if (irq !== 1'b1) begin nf++; $display("FAIL reset_irq: got %b want 1", irq); end
    rst = 1'b1;
    tick();
    rd(4'h4, v);
    nc++; if (v !== 32'h4) begin nf++; $display("FAIL reset_status: got %h want 4", v); end
    rd(4'h8, v);
    nc++; if (v !== 32'd16) begin nf++; $display("FAIL reset_div: got %h want 10", v); end
  endtask

  task automatic test_single();
    int c0, s, e;
    logic [31:0] v;
    c0 = cyc;
    store(4'h0, 32'h55);
    wait_until(c0 + NB*16 + 20);
    s = find_low(c0, cyc);
    nc++;
    if (s < 0) begin nf++; $display("FAIL single_start: got no start bit want one"); end
    else begin
      e = frame_err(s, 8'h55, 16);
      nc++; if (e !== 0) begin nf++; $display("FAIL single_frame: got %0d bad samples want 0", e); end
      nc++; if (hist[(s + NB*16) % HN] !== 1'b1) begin nf++; $display("FAIL single_end: got %b want 1", hist[(s + NB*16) % HN]); end
    end
    nc++; if (irq !== 1'b1) begin nf++; $display("FAIL single_irq: got %b want 1", irq); end
    rd(4'h4, v);
    nc++; if (v !== 32'h4) begin nf++; $display("FAIL single_status: got %h want 4", v); end
  endtask

  task automatic test_overflow();
    int c0, s, e;
    logic [31:0] v;
    logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    c0 = cyc;
    for (int i = 0; i < 6; i++) store(4'h0, {24'h0, bytes[i]});
    rd(4'h4, v);
    nc++; if (v !== 32'hB) begin nf++; $display("FAIL ovf_status1: got %h want b", v); end
    rd(4'h4, v);
    nc++; if (v !== 32'h3) begin nf++; $display("FAIL ovf_status2: got %h want 3", v); end
    wait_until(c0 + 5*NB*16 + 30);
    s = find_low(c0, cyc);
    nc++;
    if (s < 0) begin nf++; $display("FAIL ovf_start: got no start bit want one"); end
    else begin
      for (int i = 0; i < 5; i++) begin
        e = frame_err(s + i*NB*16, bytes[i], 16);
        nc++; if (e !== 0) begin nf++; $display("FAIL ovf_frame%0d: got %0d bad samples want 0", i, e); end
      end
      nc++; if (find_low(s + 5*NB*16, cyc) !== -1) begin nf++; $display("FAIL ovf_dropped: got extra frame want none"); end
    end
    nc++; if (irq !== 1'b1) begin nf++; $display("FAIL ovf_irq: got %b want 1", irq); end
  endtask

  task automatic test_back_to_back();
    int c0, s, e;
    c0 = cyc;
    store(4'h0, 32'hA5);
    store(4'h0, 32'h3C);
    wait_until(c0 + 2*NB*16 + 20);
    s = find_low(c0, cyc);
    nc++;
    if (s < 0) begin nf++; $display("FAIL b2b_start: got no start bit want one"); end
    else begin
      e = frame_err(s, 8'hA5, 16) + frame_err(s + NB*16, 8'h3C, 16);
      nc++; if (e !== 0) begin nf++; $display("FAIL b2b_frames: got %0d bad samples want 0", e); end
      nc++; if (find_low(s + 2*NB*16, cyc) !== -1) begin nf++; $display("FAIL b2b_end: got low after %0d cycles want idle", 2*NB*16); end
    end
  endtask

  task automatic test_div_change();
    int c0, s, e;
    logic [31:0] v;
    c0 = cyc;
    store(4'h0, 32'h0F);
    store(4'h0, 32'hF0);
    store(4'h8, 32'd4);
    wait_until(c0 + NB*16 + NB*4 + 20);
    s = find_low(c0, cyc);
    nc++;
    if (s < 0) begin nf++; $display("FAIL div_start: got no start bit want one"); end
    else begin
      e = frame_err(s, 8'h0F, 16);
      nc++; if (e !== 0) begin nf++; $display("FAIL div_frame16: got %0d bad samples want 0", e); end
      e = frame_err(s + NB*16, 8'hF0, 4);
      nc++; if (e !== 0) begin nf++; $display("FAIL div_frame4: got %0d bad samples want 0", e); end
      nc++; if (find_low(s + NB*16 + NB*4, cyc) !== -1) begin nf++; $display("FAIL div_end: got low after frame want idle"); end
    end
    rd(4'h8, v);
    nc++; if (v !== 32'd4) begin nf++; $display("FAIL div_read: got %h want 4", v); end
  endtask

  task automatic test_div_zero();
    int c0, s, e;
    logic [31:0] v;
    store(4'h8, 32'd0);
    rd(4'h8, v);
    nc++; if (v !== 32'd0) begin nf++; $display("FAIL div0_read: got %h want 0", v); end
    c0 = cyc;
    store(4'h0, 32'h96);
    wait_until(c0 + NB + 20);
    s = find_low(c0, cyc);
    nc++;
    if (s < 0) begin nf++; $display("FAIL div0_start: got no start bit want one"); end
    else begin
      e = frame_err(s, 8'h96, 1);
      nc++; if (e !== 0) begin nf++; $display("FAIL div0_frame: got %0d bad samples want 0", e); end
      nc++; if (find_low(s + NB, cyc) !== -1) begin nf++; $display("FAIL div0_end: got low after frame want idle"); end
    end
    store(4'h8, 32'd16);
  endtask

  task automatic test_unmapped();
    logic [31:0] v;
    store(4'hC, 32'h0000_0005);
    rd(4'hC, v);
    nc++; if (v !== 32'h0) begin nf++; $display("FAIL unmapped_c: got %h want 0", v); end
    rd(4'h2, v);
    nc++; if (v !== 32'h0) begin nf++; $display("FAIL unmapped_2: got %h want 0", v); end
    rd(4'h8, v);
    nc++; if (v !== 32'd16) begin nf++; $display("FAIL unmapped_div: got %h want 10", v); end
    rd(4'h4, v);
    nc++; if (v !== 32'h4) begin nf++; $display("FAIL unmapped_status: got %h want 4", v); end
  endtask

  task automatic test_reset_mid_frame();
    int c0;
    logic [31:0] v;
    store(4'h8, 32'd8);
    store(4'h0, 32'h00);
    repeat (30) tick();
    nc++; if (tx !== 1'b0) begin nf++; $display("FAIL mid_tx_data: got %b want 0", tx); end
    nc++; if (irq !== 1'b0) begin nf++; $display("FAIL mid_irq_busy: got %b want 0", irq); end
    rst = 1'b0;
    #1;
    nc++; if (tx !== 1'b1) begin nf++; $display("FAIL mid_tx_async: got %b want 1", tx); end
    tick();
    rst = 1'b1;
    tick();
    rd(4'h4, v);
    nc++; if (v !== 32'h4) begin nf++; $display("FAIL mid_status: got %h want 4", v); end
    rd(4'h8, v);
    nc++; if (v !== 32'd16) begin nf++; $display("FAIL mid_div: got %h want 10", v); end
    c0 = cyc;
    repeat (40) tick();
    nc++; if (find_low(c0, cyc) !== -1) begin nf++; $display("FAIL mid_idle: got low after reset want idle"); end
    nc++; if (irq !== 1'b1) begin nf++; $display("FAIL mid_irq: got %b want 1", irq); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_div_change();
    test_div_zero();
    test_unmapped();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
